// File: rtl/serial_paralelo_2b.sv
// serial_paralelo_2b: 2-bit serial to 9-bit word deserializer with comma alignment.
// Runs on clk16f only; the word rate is recovered as a one-cycle strobe.
module serial_paralelo_2b #(
    parameter logic [7:0] COMMA   = 8'hBC,
    parameter int         BC_LOCK = 4
) (
    input  logic       clk16f,
    input  logic       reset,
    input  logic [1:0] serial,
    output logic [8:0] paralelo_out,
    output logic       word_strobe,
    output logic       active
);
    localparam int CW = $clog2(BC_LOCK + 1);
    localparam logic [CW-1:0] LOCK_M1 = CW'(BC_LOCK - 1);

    typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;

    state_t          state_q, state_d;
    logic [7:0]      sr_q, sr_d;
    logic [1:0]      phase_q, phase_d;
    logic [CW-1:0]   bc_q, bc_d;
    logic [8:0]      out_q, out_d;
    logic            strobe_q, strobe_d;
    logic            is_comma, boundary;

    assign is_comma     = sr_q == COMMA;
    assign boundary     = phase_q == 2'd0;
    assign paralelo_out = out_q;
    assign word_strobe  = strobe_q;
    assign active       = state_q == ACTIVE;

    always_comb begin
        sr_d     = {sr_q[5:0], serial};
        phase_d  = phase_q + 2'd1;
        state_d  = state_q;
        bc_d     = bc_q;
        out_d    = out_q;
        strobe_d = 1'b0;
        case (state_q)
            SEARCH: if (is_comma) begin
                // The matching cycle is treated as a boundary, so realign phase here.
                phase_d = 2'd1;
                bc_d    = CW'(1);
                state_d = (BC_LOCK == 1) ? ACTIVE : ALIGN;
            end
            ALIGN: if (boundary) begin
                if (is_comma) begin
                    bc_d    = bc_q + 1'b1;
                    state_d = (bc_q == LOCK_M1) ? ACTIVE : ALIGN;
                end else begin
                    bc_d    = '0;
                    state_d = SEARCH;
                end
            end
            ACTIVE: if (boundary) begin
                strobe_d = 1'b1;
                out_d    = is_comma ? 9'h000 : {1'b1, sr_q};
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk16f or posedge reset) begin
        if (reset) begin
            state_q  <= SEARCH;
            sr_q     <= '0;
            phase_q  <= '0;
            bc_q     <= '0;
            out_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            phase_q  <= phase_d;
            bc_q     <= bc_d;
            out_q    <= out_d;
            strobe_q <= strobe_d;
        end
    end
endmodule

// File: tb/tb_serial_paralelo_2b.sv
// tb_serial_paralelo_2b: directed checks of alignment, lock, word recovery and reset.
module tb_serial_paralelo_2b;
    logic       clk16f = 1'b0;
    logic       reset  = 1'b1;
    logic [1:0] serial = 2'b00;
    logic [8:0] paralelo_out;
    logic       word_strobe;
    logic       active;
    int         n_assert = 0;
    int         n_fail   = 0;

    serial_paralelo_2b dut (
        .clk16f(clk16f),
        .reset(reset),
        .serial(serial),
        .paralelo_out(paralelo_out),
        .word_strobe(word_strobe),
        .active(active)
    );

    always #5 clk16f = ~clk16f;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [1:0] s);
        @(negedge clk16f);
        serial = s;
        @(posedge clk16f);
        #1;
    endtask

    // Sends one byte MSB-first; st: strobe expected after the first pair, o: output held
    // over the whole byte, a0/a: active after the first pair / after the rest.
    task automatic word(input logic [7:0] b, input logic st, input logic [8:0] o,
                        input logic a0, input logic a);
        for (int i = 0; i < 4; i++) begin
            step(b[7-2*i -: 2]);
            chk("strobe", 9'(word_strobe), 9'(st && i == 0));
            chk("out", paralelo_out, o);
            chk("active", 9'(active), 9'(i == 0 ? a0 : a));
        end
    endtask

    task automatic do_reset();
        @(negedge clk16f);
        reset = 1'b1;
        #1;
        chk("rst_out", paralelo_out, 9'h000);
        chk("rst_strobe", 9'(word_strobe), 9'h000);
        chk("rst_active", 9'(active), 9'h000);
        @(negedge clk16f);
        reset = 1'b0;
    endtask

    initial begin
        // 1: reset held with random serial activity
        for (int i = 0; i < 8; i++) begin
            @(negedge clk16f);
            serial = 2'($urandom_range(0, 3));
            @(posedge clk16f);
            #1;
            chk("hold_out", paralelo_out, 9'h000);
            chk("hold_strobe", 9'(word_strobe), 9'h000);
            chk("hold_active", 9'(active), 9'h000);
        end
        @(negedge clk16f);
        reset = 1'b0;
        // 2: four commas lock; active rises one edge after the 4th comma boundary
        for (int i = 0; i < 4; i++) word(8'hBC, 1'b0, 9'h000, 1'b0, 1'b0);
        // 3: data words, one strobe every 4 cycles
        word(8'hFF, 1'b0, 9'h000, 1'b1, 1'b1);
        word(8'h55, 1'b1, 9'h1FF, 1'b1, 1'b1);
        word(8'h00, 1'b1, 9'h155, 1'b1, 1'b1);
        word(8'hBC, 1'b1, 9'h100, 1'b1, 1'b1);
        word(8'h3C, 1'b1, 9'h000, 1'b1, 1'b1);
        // 4: stray symbol shifts alignment by one pair
        do_reset();
        step(2'b01);
        chk("stray_active", 9'(active), 9'h000);
        for (int i = 0; i < 4; i++) word(8'hBC, 1'b0, 9'h000, 1'b0, 1'b0);
        word(8'hFF, 1'b0, 9'h000, 1'b1, 1'b1);
        word(8'h55, 1'b1, 9'h1FF, 1'b1, 1'b1);
        word(8'h00, 1'b1, 9'h155, 1'b1, 1'b1);
        word(8'hA7, 1'b1, 9'h100, 1'b1, 1'b1);
        // 5: broken comma run sends the aligner back to search
        do_reset();
        word(8'hBC, 1'b0, 9'h000, 1'b0, 1'b0);
        word(8'hBC, 1'b0, 9'h000, 1'b0, 1'b0);
        word(8'h55, 1'b0, 9'h000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) word(8'hBC, 1'b0, 9'h000, 1'b0, 1'b0);
        // 6: idle comma in ACTIVE, then reset mid-word
        word(8'hA5, 1'b0, 9'h000, 1'b1, 1'b1);
        word(8'hBC, 1'b1, 9'h1A5, 1'b1, 1'b1);
        word(8'h3C, 1'b1, 9'h000, 1'b1, 1'b1);
        step(2'b11);
        chk("pre_rst_strobe", 9'(word_strobe), 9'h001);
        chk("pre_rst_out", paralelo_out, 9'h13C);
        #2;
        reset = 1'b1;
        #1;
        chk("async_out", paralelo_out, 9'h000);
        chk("async_strobe", 9'(word_strobe), 9'h000);
        chk("async_active", 9'(active), 9'h000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
